wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Retirement-side trace collector for the pipelined MIPS core. It captures register-file writes from the W stage and data-memory stores from the M stage each cycle, and filters writes to $0. Events are queued in program order in a first-word-fall-through FIFO. They leave over a valid/ready stream toward the simulation/host side, so the core's architectural effects can be checked against a reference model without stalling the pipeline.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥4
- DROP_W, 16, width of the saturating drop counter

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- w_grf_we  input  1  W-stage register write enable
- w_grf_addr  input  5  W-stage destination register
- w_grf_wdata  input  32  W-stage write data
- w_pc  input  32  PC of the W-stage instruction
- m_dm_we  input  1  M-stage store enable
- m_dm_addr  input  32  M-stage store byte address
- m_dm_wdata  input  32  M-stage store data
- m_pc  input  32  PC of the M-stage instruction
- trace_valid  output  1  head entry available
- trace_ready  input  1  consumer accepts head
- trace_kind  output  1  0 = register write, 1 = memory store
- trace_pc  output  32  PC of the event
- trace_addr  output  32  register number zero-extended (kind 0) or byte address (kind 1)
- trace_data  output  32  written value
- fifo_count  output  $clog2(DEPTH)+1  occupied entries
- drop_count  output  DROP_W  events lost to overflow, saturating

## Operation
- Event qualification, per cycle:
  - A register event exists when w_grf_we=1 and w_grf_addr≠0.
  - A store event exists when m_dm_we=1.
- Ordering: when both events exist in one cycle, the register event is older (W precedes M) and is written to the FIFO first. The store event occupies the next slot.
- Each entry is 97 bits: kind, pc, addr, data.
- Pop: occurs when trace_valid=1 and trace_ready=1.
- Free space in a cycle is DEPTH − fifo_count + (pop ? 1 : 0), so a pop frees a slot for a push on the same edge.
- Overflow handling:
  - Events are accepted in program order while space remains.
  - The remaining events are dropped, the older one never being dropped in favour of the younger.
  - drop_count increments by the number dropped (0, 1 or 2) and saturates at 2^DROP_W−1.
- Storage and pointers:
  - Storage is a register array with write and read pointers of $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH.
  - fifo_count is updated as count + pushes − pops (pushes 0..2, pops 0..1) and never exceeds DEPTH.
- trace_valid = (fifo_count≠0). trace_kind/pc/addr/data show the entry at the read pointer combinationally. They are don't-care while trace_valid=0 but must not be X after reset.
- The pipeline is never back-pressured; this block has no stall output.

## Timing
- Reset (asynchronous assert, applies immediately) clears:
  - fifo_count=0, trace_valid=0, drop_count=0
  - both pointers=0
  - storage entries, to zero
- Capture latency: an event present before rising edge N is visible on the trace outputs in the cycle after edge N. This holds when it lands at the head of an empty FIFO.
- Handshake:
  - The head is stable while trace_valid=1 and trace_ready=0.
  - trace_ready may be high while trace_valid=0; this has no effect.
- Two-event cycle into an empty FIFO: the register event is at the head after edge N, and the store follows on the next pop.
- Full FIFO (count=DEPTH) with simultaneous pop and one event: the event is accepted, count stays DEPTH, and nothing is dropped.
- Full FIFO with pop and two events: the register event is accepted and the store is dropped (drop_count+1).
- Full FIFO without pop: all events that cycle are dropped.
- Count DEPTH−1 with two events and no pop: the first is accepted, the second is dropped.
- Reset asserted mid-stream discards all queued entries. Events present in the cycle reset deasserts are captured at the first edge after deassertion.

## Test plan
- Reset, then a single W write of $5←0x1234 at pc 0x3000 → next cycle trace_valid=1, kind=0, addr=5, data=0x1234, pc=0x3000, fifo_count=1.
- Write to $0 plus a store of 0xdead to 0x10 at pc 0x3004, same cycle → only the store is queued; kind=1, addr=0x10, fifo_count=1.
- Both events in one cycle, trace_ready held 1 → output order is the register entry then the store, on consecutive cycles; fifo_count returns to 0.
- With trace_ready=0 and DEPTH=16, issue 10 cycles of dual events → exactly 16 entries held, oldest first; drop_count=4; the head is unchanged while ready is low.
- At full, assert trace_ready with one register event per cycle for 20 cycles → no drops; entries drain in order; fifo_count stays 16.
- Assert reset asynchronously (between edges) with 7 queued → trace_valid and fifo_count go 0 immediately, drop_count=0; after deassertion the next event appears alone at the head.

Source files
------------

// File: rtl/wb_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_trace_buffer_if
//  Purpose  : Capture-side event inputs and host-side trace stream of the
//             retirement trace buffer.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_trace_buffer_if #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
);
    logic                     w_grf_we;
    logic [4:0]               w_grf_addr;
    logic [31:0]              w_grf_wdata;
    logic [31:0]              w_pc;
    logic                     m_dm_we;
    logic [31:0]              m_dm_addr;
    logic [31:0]              m_dm_wdata;
    logic [31:0]              m_pc;
    logic                     trace_valid;
    logic                     trace_ready;
    logic                     trace_kind;
    logic [31:0]              trace_pc;
    logic [31:0]              trace_addr;
    logic [31:0]              trace_data;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic [DROP_W-1:0]        drop_count;

    modport slave (
        input  w_grf_we, w_grf_addr, w_grf_wdata, w_pc,
        input  m_dm_we, m_dm_addr, m_dm_wdata, m_pc,
        input  trace_ready,
        output trace_valid, trace_kind, trace_pc, trace_addr, trace_data,
        output fifo_count, drop_count
    );

    modport master (
        output w_grf_we, w_grf_addr, w_grf_wdata, w_pc,
        output m_dm_we, m_dm_addr, m_dm_wdata, m_pc,
        output trace_ready,
        input  trace_valid, trace_kind, trace_pc, trace_addr, trace_data,
        input  fifo_count, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : wb_trace_buffer
//  Purpose  : Collects W-stage register writes and M-stage stores in program
//             order into a FWFT FIFO drained over a valid/ready stream.
//  Revision : 1.0  initial release
// ============================================================================
module wb_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    wb_trace_buffer_if.slave   bus
);
    localparam int c_AW      = $clog2(DEPTH);
    localparam int c_CW      = c_AW + 1;
    localparam int c_ENTRY_W = 97;
    localparam int c_DW1     = DROP_W + 1;

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]      r_wr;
    logic [c_AW-1:0]      r_rd;
    logic [c_CW-1:0]      r_count;
    logic [DROP_W-1:0]    r_drop;

    logic                 w_reg_ev;
    logic                 w_st_ev;
    logic                 w_pop;
    logic [c_CW-1:0]      w_free;
    logic [1:0]           w_n_ev;
    logic [1:0]           w_n_acc;
    logic [1:0]           w_n_drop;
    logic [c_ENTRY_W-1:0] w_reg_entry;
    logic [c_ENTRY_W-1:0] w_st_entry;
    logic [c_ENTRY_W-1:0] w_e0;
    logic [c_AW-1:0]      w_wr_p1;
    logic [c_DW1-1:0]     w_drop_sum;
    logic [c_ENTRY_W-1:0] w_head;

    always_comb begin
        w_reg_ev    = bus.w_grf_we && (bus.w_grf_addr != 5'd0);
        w_st_ev     = bus.m_dm_we;
        w_pop       = (r_count != '0) && bus.trace_ready;
        w_free      = c_CW'(DEPTH) - r_count + c_CW'(w_pop);
        w_n_ev      = 2'(w_reg_ev) + 2'(w_st_ev);
        w_reg_entry = {1'b0, bus.w_pc, 27'd0, bus.w_grf_addr, bus.w_grf_wdata};
        w_st_entry  = {1'b1, bus.m_pc, bus.m_dm_addr, bus.m_dm_wdata};
        // The register event is older, so it always takes the first free slot
        w_e0        = w_reg_ev ? w_reg_entry : w_st_entry;
        w_wr_p1     = r_wr + c_AW'(1);
        w_n_acc     = w_n_ev;
        if (c_CW'(w_n_ev) > w_free) begin
            w_n_acc = w_free[1:0];
        end
        w_n_drop    = w_n_ev - w_n_acc;
        w_drop_sum  = c_DW1'(r_drop) + c_DW1'(w_n_drop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_n_acc != 2'd0) begin
                r_mem[r_wr] <= w_e0;
            end
            if (w_n_acc == 2'd2) begin
                r_mem[w_wr_p1] <= w_st_entry;
            end
            r_wr    <= r_wr + c_AW'(w_n_acc);
            r_rd    <= r_rd + c_AW'(w_pop);
            r_count <= r_count + c_CW'(w_n_acc) - c_CW'(w_pop);
            r_drop  <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
        end
    end

    assign w_head          = r_mem[r_rd];
    assign bus.trace_valid = (r_count != '0);
    assign bus.trace_kind  = w_head[96];
    assign bus.trace_pc    = w_head[95:64];
    assign bus.trace_addr  = w_head[63:32];
    assign bus.trace_data  = w_head[31:0];
    assign bus.fifo_count  = r_count;
    assign bus.drop_count  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_trace_buffer
//  Purpose  : Scoreboard bench for wb_trace_buffer with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_trace_buffer;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    ev_t  exp_q[$];

    wb_trace_buffer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    wb_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the head is consumed on the next rising edge when valid&ready
    always @(negedge clk) begin
        if (!reset && bus.trace_valid && bus.trace_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("out_kind", 32'(bus.trace_kind), 32'(e.kind));
                check("out_pc",   bus.trace_pc,   e.pc);
                check("out_addr", bus.trace_addr, e.addr);
                check("out_data", bus.trace_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.w_grf_we = 1'b0; bus.w_grf_addr = 5'd0; bus.w_grf_wdata = 32'd0; bus.w_pc = 32'd0;
        bus.m_dm_we  = 1'b0; bus.m_dm_addr  = 32'd0; bus.m_dm_wdata = 32'd0; bus.m_pc = 32'd0;
    endtask

    task automatic drive_reg(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc, input bit expect_it);
        bus.w_grf_we = 1'b1; bus.w_grf_addr = a; bus.w_grf_wdata = d; bus.w_pc = pc;
        if (expect_it) exp_q.push_back('{1'b0, pc, {27'd0, a}, d});
    endtask

    task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc, input bit expect_it);
        bus.m_dm_we = 1'b1; bus.m_dm_addr = a; bus.m_dm_wdata = d; bus.m_pc = pc;
        if (expect_it) exp_q.push_back('{1'b1, pc, a, d});
    endtask

    task automatic drain(input int budget);
        int k;
        bus.trace_ready = 1'b1;
        k = 0;
        while (bus.fifo_count != 0 && k < budget) begin
            step();
            k++;
        end
        check("drain_done", 32'(bus.fifo_count), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.trace_ready = 1'b0;
        idle();
        repeat (2) step();
        reset = 1'b0;
        step();
        check("rst_valid", 32'(bus.trace_valid), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_drop",  32'(bus.drop_count), 32'd0);
        check("rst_data",  bus.trace_data, 32'd0);

        // Single register write
        drive_reg(5'd5, 32'h1234, 32'h3000, 1'b1);
        step(); idle();
        check("t1_valid", 32'(bus.trace_valid), 32'd1);
        check("t1_kind",  32'(bus.trace_kind), 32'd0);
        check("t1_addr",  bus.trace_addr, 32'd5);
        check("t1_data",  bus.trace_data, 32'h1234);
        check("t1_pc",    bus.trace_pc, 32'h3000);
        check("t1_count", 32'(bus.fifo_count), 32'd1);
        drain(4);

        // $0 write filtered, store kept
        bus.trace_ready = 1'b0;
        drive_reg(5'd0, 32'hffff, 32'h3004, 1'b0);
        drive_st(32'h10, 32'hdead, 32'h3004, 1'b1);
        step(); idle();
        check("t2_kind",  32'(bus.trace_kind), 32'd1);
        check("t2_addr",  bus.trace_addr, 32'h10);
        check("t2_count", 32'(bus.fifo_count), 32'd1);
        drain(4);

        // Dual event with ready held high
        bus.trace_ready = 1'b1;
        drive_reg(5'd7, 32'h7777, 32'h3008, 1'b1);
        drive_st(32'h20, 32'hbeef, 32'h300c, 1'b1);
        step(); idle();
        check("t3_count_a", 32'(bus.fifo_count), 32'd2);
        check("t3_kind_a",  32'(bus.trace_kind), 32'd0);
        step();
        check("t3_count_b", 32'(bus.fifo_count), 32'd1);
        check("t3_kind_b",  32'(bus.trace_kind), 32'd1);
        step();
        check("t3_count_c", 32'(bus.fifo_count), 32'd0);

        // Overflow: 10 dual cycles, ready low
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_reg(5'(i + 1), 32'ha000_0000 + 32'(i), 32'h5000 + 32'(8 * i), i < 8);
            drive_st(32'h100 + 32'(4 * i), 32'hb000_0000 + 32'(i), 32'h5004 + 32'(8 * i), i < 8);
            step();
        end
        idle();
        check("t4_count", 32'(bus.fifo_count), 32'd16);
        check("t4_drop",  32'(bus.drop_count), 32'd4);
        for (int i = 0; i < 3; i++) begin
            check("t4_head_pc",   bus.trace_pc, 32'h5000);
            check("t4_head_data", bus.trace_data, 32'ha000_0000);
            step();
        end

        // Full with pop and one event per cycle
        bus.trace_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_reg(5'((i % 31) + 1), 32'h5000 + 32'(i), 32'h4000 + 32'(4 * i), 1'b1);
            step();
            check("t5_count", 32'(bus.fifo_count), 32'd16);
        end
        idle();
        check("t5_drop", 32'(bus.drop_count), 32'd4);

        // Full with pop and two events: store dropped
        drive_reg(5'd9, 32'h9999, 32'h6000, 1'b1);
        drive_st(32'h40, 32'h4444, 32'h6004, 1'b0);
        step(); idle();
        check("t6_count", 32'(bus.fifo_count), 32'd16);
        check("t6_drop",  32'(bus.drop_count), 32'd5);
        step();
        bus.trace_ready = 1'b0;
        check("t6_count15", 32'(bus.fifo_count), 32'd15);

        // DEPTH-1 with two events, no pop
        drive_reg(5'd10, 32'haaaa, 32'h6008, 1'b1);
        drive_st(32'h44, 32'h5555, 32'h600c, 1'b0);
        step(); idle();
        check("t7_count", 32'(bus.fifo_count), 32'd16);
        check("t7_drop",  32'(bus.drop_count), 32'd6);

        // Full without pop: everything dropped
        drive_reg(5'd11, 32'hbbbb, 32'h6010, 1'b0);
        drive_st(32'h48, 32'h6666, 32'h6014, 1'b0);
        step(); idle();
        check("t8_count", 32'(bus.fifo_count), 32'd16);
        check("t8_drop",  32'(bus.drop_count), 32'd8);

        // Drain to 7 then reset between edges
        bus.trace_ready = 1'b1;
        repeat (9) step();
        bus.trace_ready = 1'b0;
        check("t9_count7", 32'(bus.fifo_count), 32'd7);
        #2 reset = 1'b1;
        #1;
        check("t9_valid", 32'(bus.trace_valid), 32'd0);
        check("t9_count", 32'(bus.fifo_count), 32'd0);
        check("t9_drop",  32'(bus.drop_count), 32'd0);
        exp_q.delete();
        step();
        reset = 1'b0;
        drive_reg(5'd3, 32'hc0de, 32'h7000, 1'b1);
        step(); idle();
        check("t9_new_count", 32'(bus.fifo_count), 32'd1);
        check("t9_new_data",  bus.trace_data, 32'hc0de);
        drain(4);
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
